// File: rtl/lcd_pkg.sv
// lcd_pkg: state encodings, bus widths, command codes and helpers for the LCD write engine
package lcd_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_EHIGH = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        EHIGH = ST_EHIGH,
        HOLD  = ST_HOLD,
        WAIT  = ST_WAIT,
        DONE  = ST_DONE
    } state_t;
    localparam int BUS_4BIT = 4;
    localparam int BUS_8BIT = 8;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/lcd_tick_timer.sv
// lcd_tick_timer: loadable down-counter that parks at zero and flags it
module lcd_tick_timer #(
    parameter int W = 2
) (
    input  logic         clk_1ms,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk_1ms or posedge reset)
        if (reset) cnt <= '0;
        else       cnt <= load ? load_val : (cnt != '0 ? cnt - 1'b1 : cnt);
    assign zero = cnt == '0;
endmodule

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: HD44780 bus write sequencer (4/8-bit); define LCD_LONG_CMD_EN for long clear/home execute time
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int BUS_WIDTH       = 8,
    parameter int SETUP_TICKS     = 1,
    parameter int E_HIGH_TICKS    = 1,
    parameter int HOLD_TICKS      = 1,
    parameter int EXEC_TICKS      = 1,
    parameter int LONG_EXEC_TICKS = 2
) (
    input  logic                 clk_1ms,
    input  logic                 reset,
    input  logic                 wr_req,
    input  logic                 reg_sel,
    input  logic [7:0]           data_in,
    output logic                 busy,
    output logic                 done,
    output logic                 lcd_e,
    output logic                 lcd_rw,
    output logic                 lcd_rs,
    output logic [BUS_WIDTH-1:0] lcd_db
);
    localparam int MAXT = max2(max2(max2(SETUP_TICKS, E_HIGH_TICKS), max2(HOLD_TICKS, EXEC_TICKS)), LONG_EXEC_TICKS);
    localparam int CW   = $clog2(MAXT + 1);
    localparam bit FOUR = BUS_WIDTH == BUS_4BIT;

    generate
        if (BUS_WIDTH != BUS_4BIT && BUS_WIDTH != BUS_8BIT) begin : g_bad_width
            $error("lcd_write_engine: BUS_WIDTH must be 4 or 8");
        end
    endgenerate

    state_t        state;
    logic [7:0]    data_q;
    logic          nib;
    logic          zero;
    logic          load;
    logic [CW-1:0] load_val;
    logic [CW-1:0] exec_val;
    logic          x_zero;
    logic          is_long;
    logic          last;
    logic [7:0]    first_w;
    logic [7:0]    next_w;

`ifdef LCD_LONG_CMD_EN
    assign is_long = !lcd_rs && (data_q == CMD_CLEAR || data_q[7:1] == CMD_HOME[7:1]);
`else
    assign is_long = 1'b0;
`endif

    // lcd_rs still holds the latched flag when HOLD exits, so it qualifies the long-command check
    assign exec_val = is_long ? CW'(LONG_EXEC_TICKS - 1) : CW'(EXEC_TICKS - 1);
    assign x_zero   = is_long ? (LONG_EXEC_TICKS == 0) : (EXEC_TICKS == 0);
    assign last     = !FOUR || nib;
    assign first_w  = FOUR ? {4'h0, data_in[7:4]} : data_in;
    assign next_w   = FOUR ? {4'h0, data_q[3:0]} : data_q;
    assign load     = (state == IDLE && wr_req) || (state inside {SETUP, EHIGH, HOLD, WAIT} && zero);
    assign load_val = state == IDLE            ? CW'(SETUP_TICKS - 1) :
                      state == SETUP           ? CW'(E_HIGH_TICKS - 1) :
                      state == EHIGH           ? CW'(HOLD_TICKS - 1) :
                      (state == HOLD && !last) ? CW'(SETUP_TICKS - 1) : exec_val;

    lcd_tick_timer #(.W(CW)) u_timer (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .load    (load),
        .load_val(load_val),
        .zero    (zero)
    );

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            data_q <= '0;
            nib    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            lcd_e  <= 1'b0;
            lcd_rw <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_db <= '0;
        end else begin
            lcd_rw <= 1'b0;
            case (state)
                IDLE: if (wr_req) begin
                    state  <= SETUP;
                    data_q <= data_in;
                    nib    <= 1'b0;
                    busy   <= 1'b1;
                    lcd_rs <= reg_sel;
                    lcd_db <= first_w[BUS_WIDTH-1:0];
                end
                SETUP: if (zero) begin
                    state <= EHIGH;
                    lcd_e <= 1'b1;
                end
                EHIGH: if (zero) begin
                    state <= HOLD;
                    lcd_e <= 1'b0;
                end
                HOLD: if (zero) begin
                    if (!last) begin
                        state  <= SETUP;
                        nib    <= 1'b1;
                        lcd_db <= next_w[BUS_WIDTH-1:0];
                    end else begin
                        state  <= x_zero ? DONE : WAIT;
                        busy   <= !x_zero;
                        done   <= x_zero;
                        lcd_rs <= 1'b0;
                        lcd_db <= '0;
                    end
                end
                WAIT: if (zero) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: directed checks of 8-bit, 4-bit and slow-setup/no-exec engines sharing one stimulus
module tb_lcd_write_engine;
    logic       clk_1ms = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0;
    logic       reg_sel = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic busy8, done8, e8, rw8, rs8;
    logic [7:0] db8;
    logic busy4, done4, e4, rw4, rs4;
    logic [3:0] db4;
    logic busyx, donex, ex, rwx, rsx;
    logic [7:0] dbx;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_e8, m_d8, m_b8, m_rs8, m_e4, m_d4, m_b4, m_rs4, m_ex, m_dx, m_bx, m_rsx, m_rw;
    logic [7:0]  t_db8 [16];
    logic [3:0]  t_db4 [16];
    logic [7:0]  t_dbx [16];

`ifdef LCD_LONG_CMD_EN
    localparam bit LONG = 1'b1;
`else
    localparam bit LONG = 1'b0;
`endif

    always #5 clk_1ms = ~clk_1ms;

    lcd_write_engine dut8 (
        .clk_1ms(clk_1ms), .reset(reset), .wr_req(wr_req), .reg_sel(reg_sel), .data_in(data_in),
        .busy(busy8), .done(done8), .lcd_e(e8), .lcd_rw(rw8), .lcd_rs(rs8), .lcd_db(db8)
    );
    lcd_write_engine #(.BUS_WIDTH(4)) dut4 (
        .clk_1ms(clk_1ms), .reset(reset), .wr_req(wr_req), .reg_sel(reg_sel), .data_in(data_in),
        .busy(busy4), .done(done4), .lcd_e(e4), .lcd_rw(rw4), .lcd_rs(rs4), .lcd_db(db4)
    );
    lcd_write_engine #(.SETUP_TICKS(3), .EXEC_TICKS(0)) dutx (
        .clk_1ms(clk_1ms), .reset(reset), .wr_req(wr_req), .reg_sel(reg_sel), .data_in(data_in),
        .busy(busyx), .done(donex), .lcd_e(ex), .lcd_rw(rwx), .lcd_rs(rsx), .lcd_db(dbx)
    );

    // bit k of each mask / entry k of each trace is the output seen after edge k; req bit k drives wr_req at edge k
    task automatic run(input logic rs, input logic [7:0] d, input logic [15:0] req, input int n);
        m_e8 = '0; m_d8 = '0; m_b8 = '0; m_rs8 = '0;
        m_e4 = '0; m_d4 = '0; m_b4 = '0; m_rs4 = '0;
        m_ex = '0; m_dx = '0; m_bx = '0; m_rsx = '0;
        @(negedge clk_1ms);
        reg_sel = rs;
        data_in = d;
        wr_req  = req[0];
        for (int k = 0; k < n; k++) begin
            @(posedge clk_1ms);
            @(negedge clk_1ms);
            wr_req = (k + 1 < 16) ? req[k+1] : 1'b0;
            m_e8[k] = e8; m_d8[k] = done8; m_b8[k] = busy8; m_rs8[k] = rs8; t_db8[k] = db8;
            m_e4[k] = e4; m_d4[k] = done4; m_b4[k] = busy4; m_rs4[k] = rs4; t_db4[k] = db4;
            m_ex[k] = ex; m_dx[k] = donex; m_bx[k] = busyx; m_rsx[k] = rsx; t_dbx[k] = dbx;
            m_rw[k] = m_rw[k] | rw8 | rw4 | rwx;
        end
        wr_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_1ms);
        n_cmp++;
        if ({busy8, done8, e8, rw8, rs8, db8} !== 13'h0) begin
            n_bad++; $display("FAIL reset_dut8: got %h exp 0", {busy8, done8, e8, rw8, rs8, db8});
        end
        n_cmp++;
        if ({busy4, done4, e4, rw4, rs4, db4} !== 9'h0) begin
            n_bad++; $display("FAIL reset_dut4: got %h exp 0", {busy4, done4, e4, rw4, rs4, db4});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk_1ms);
        n_cmp++;
        if ({busyx, donex, ex, rwx, rsx, dbx} !== 13'h0) begin
            n_bad++; $display("FAIL idle_dutx: got %h exp 0", {busyx, donex, ex, rwx, rsx, dbx});
        end
    endtask

    task automatic test_write8();
        m_rw = '0;
        run(1'b1, 8'hA5, 16'h0001, 8);
        n_cmp++;
        if (m_e8 !== 16'h0002) begin n_bad++; $display("FAIL w8_e: got %h exp %h", m_e8, 16'h0002); end
        n_cmp++;
        if (m_d8 !== 16'h0010) begin n_bad++; $display("FAIL w8_done: got %h exp %h", m_d8, 16'h0010); end
        n_cmp++;
        if (m_b8 !== 16'h000F) begin n_bad++; $display("FAIL w8_busy: got %h exp %h", m_b8, 16'h000F); end
        n_cmp++;
        if (m_rs8 !== 16'h0007) begin n_bad++; $display("FAIL w8_rs: got %h exp %h", m_rs8, 16'h0007); end
        n_cmp++;
        if (t_db8[0] !== 8'hA5 || t_db8[2] !== 8'hA5) begin
            n_bad++; $display("FAIL w8_db: got %h/%h exp a5/a5", t_db8[0], t_db8[2]);
        end
        n_cmp++;
        if (t_db8[3] !== 8'h00) begin n_bad++; $display("FAIL w8_db_wait: got %h exp 00", t_db8[3]); end
        n_cmp++;
        if (m_rw !== 16'h0000) begin n_bad++; $display("FAIL rw_tied: got %h exp 0000", m_rw); end
    endtask

    task automatic test_write4();
        run(1'b0, 8'h3C, 16'h0001, 10);
        n_cmp++;
        if (m_e4 !== 16'h0012) begin n_bad++; $display("FAIL w4_e: got %h exp %h", m_e4, 16'h0012); end
        n_cmp++;
        if (m_d4 !== 16'h0080) begin n_bad++; $display("FAIL w4_done: got %h exp %h", m_d4, 16'h0080); end
        n_cmp++;
        if (m_b4 !== 16'h007F) begin n_bad++; $display("FAIL w4_busy: got %h exp %h", m_b4, 16'h007F); end
        n_cmp++;
        if (m_rs4 !== 16'h0000) begin n_bad++; $display("FAIL w4_rs0: got %h exp 0000", m_rs4); end
        n_cmp++;
        if ({t_db4[0], t_db4[2], t_db4[3], t_db4[5], t_db4[6]} !== 20'h33CC0) begin
            n_bad++; $display("FAIL w4_db: got %h exp 33cc0", {t_db4[0], t_db4[2], t_db4[3], t_db4[5], t_db4[6]});
        end
        run(1'b1, 8'h96, 16'h0001, 10);
        n_cmp++;
        if (m_rs4 !== 16'h003F) begin n_bad++; $display("FAIL w4_rs1: got %h exp %h", m_rs4, 16'h003F); end
        n_cmp++;
        if ({t_db4[0], t_db4[3]} !== 8'h96) begin
            n_bad++; $display("FAIL w4_nibbles: got %h exp 96", {t_db4[0], t_db4[3]});
        end
    endtask

    task automatic test_long_cmd();
        run(1'b0, 8'h01, 16'h0001, 8);
        n_cmp++;
        if (m_d8 !== (LONG ? 16'h0020 : 16'h0010)) begin
            n_bad++; $display("FAIL long_clear: got %h exp %h", m_d8, LONG ? 16'h0020 : 16'h0010);
        end
        run(1'b1, 8'h01, 16'h0001, 8);
        n_cmp++;
        if (m_d8 !== 16'h0010) begin n_bad++; $display("FAIL data_01: got %h exp %h", m_d8, 16'h0010); end
        run(1'b0, 8'h03, 16'h0001, 8);
        n_cmp++;
        if (m_d8 !== (LONG ? 16'h0020 : 16'h0010)) begin
            n_bad++; $display("FAIL long_home3: got %h exp %h", m_d8, LONG ? 16'h0020 : 16'h0010);
        end
        run(1'b0, 8'h04, 16'h0001, 8);
        n_cmp++;
        if (m_d8 !== 16'h0010) begin n_bad++; $display("FAIL cmd_04: got %h exp %h", m_d8, 16'h0010); end
    endtask

    task automatic test_back_to_back();
        run(1'b1, 8'h55, 16'h002B, 10);
        n_cmp++;
        if (m_d8 !== 16'h0010) begin n_bad++; $display("FAIL ign_done8: got %h exp %h", m_d8, 16'h0010); end
        n_cmp++;
        if (m_b8 !== 16'h000F) begin n_bad++; $display("FAIL ign_busy8: got %h exp %h", m_b8, 16'h000F); end
        n_cmp++;
        if (m_d4 !== 16'h0080) begin n_bad++; $display("FAIL ign_done4: got %h exp %h", m_d4, 16'h0080); end
        n_cmp++;
        if (m_dx !== 16'h0020) begin n_bad++; $display("FAIL ign_donex: got %h exp %h", m_dx, 16'h0020); end
        run(1'b1, 8'h11, 16'hFFFF, 12);
        n_cmp++;
        if (m_d8 !== 16'h0410) begin n_bad++; $display("FAIL held_done8: got %h exp %h", m_d8, 16'h0410); end
        n_cmp++;
        if (m_b8 !== 16'h03CF) begin n_bad++; $display("FAIL held_busy8: got %h exp %h", m_b8, 16'h03CF); end
        n_cmp++;
        if (m_d4 !== 16'h0080) begin n_bad++; $display("FAIL held_done4: got %h exp %h", m_d4, 16'h0080); end
        repeat (20) @(negedge clk_1ms);
    endtask

    task automatic test_reset_abort();
        logic seen;
        @(negedge clk_1ms);
        reg_sel = 1'b1;
        data_in = 8'h77;
        wr_req  = 1'b1;
        @(posedge clk_1ms);
        @(negedge clk_1ms);
        wr_req = 1'b0;
        @(posedge clk_1ms);
        @(negedge clk_1ms);
        n_cmp++;
        if (e8 !== 1'b1) begin n_bad++; $display("FAIL abort_pre_e: got %b exp 1", e8); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy8, done8, e8, rs8, db8} !== 12'h0) begin
            n_bad++; $display("FAIL abort_dut8: got %h exp 0", {busy8, done8, e8, rs8, db8});
        end
        n_cmp++;
        if ({busy4, e4, rs4, db4} !== 7'h0) begin
            n_bad++; $display("FAIL abort_dut4: got %h exp 0", {busy4, e4, rs4, db4});
        end
        @(negedge clk_1ms);
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk_1ms);
            seen = seen | done8 | done4 | donex | busy8;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b exp 0", seen); end
        run(1'b1, 8'h5A, 16'h0001, 8);
        n_cmp++;
        if (m_d8 !== 16'h0010) begin n_bad++; $display("FAIL after_rst_done: got %h exp %h", m_d8, 16'h0010); end
        n_cmp++;
        if (t_db8[0] !== 8'h5A) begin n_bad++; $display("FAIL after_rst_db: got %h exp 5a", t_db8[0]); end
    endtask

    task automatic test_slow_setup();
        run(1'b1, 8'hC3, 16'h0001, 8);
        n_cmp++;
        if (m_ex !== 16'h0008) begin n_bad++; $display("FAIL ss_e: got %h exp %h", m_ex, 16'h0008); end
        n_cmp++;
        if (m_dx !== 16'h0020) begin n_bad++; $display("FAIL ss_done: got %h exp %h", m_dx, 16'h0020); end
        n_cmp++;
        if (m_bx !== 16'h001F) begin n_bad++; $display("FAIL ss_busy: got %h exp %h", m_bx, 16'h001F); end
        n_cmp++;
        if (m_rsx !== 16'h001F) begin n_bad++; $display("FAIL ss_rs: got %h exp %h", m_rsx, 16'h001F); end
        n_cmp++;
        if (t_dbx[4] !== 8'hC3 || t_dbx[5] !== 8'h00) begin
            n_bad++; $display("FAIL ss_db: got %h/%h exp c3/00", t_dbx[4], t_dbx[5]);
        end
    endtask

    initial begin
        test_reset();
        test_write8();
        test_write4();
        test_long_cmd();
        test_back_to_back();
        test_reset_abort();
        test_slow_setup();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
